// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the Knight command sequencer.
package tour_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitSent,
    StWaitResp,
    StCheck,
    StDone,
    StErr
  } seq_state_t;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrNack    = 2'd1,
    ErrTimeout = 2'd2,
    ErrAbort   = 2'd3
  } err_code_t;

  localparam logic [7:0]  POS_ACK_DEFAULT = 8'hA5;
  localparam logic [15:0] CAL_GYRO        = 16'h2000;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Command FIFO with wrap-bit pointers; full/empty are registered from the next-state pointers.
module seq_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full_q, empty_q, do_wr, do_rd;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_wr = wr_en && !full_q;
  assign do_rd = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty_q  <= (wr_ptr_d == rd_ptr_d);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Queues Knight commands and issues them one at a time to RemoteComm, checking each response.
// Build option: define SEQ_RETRY_EN to retry a failed command up to twice before erroring.
module tour_cmd_sequencer
  import tour_seq_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter logic [7:0]  POS_ACK      = POS_ACK_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [15:0]                wr_cmd,
  output logic                       full,
  output logic                       empty,
  input  logic                       start,
  input  logic                       abort,
  output logic [15:0]                cmd,
  output logic                       send_cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH+1)-1:0] n_acked
);

  localparam int unsigned CntW     = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned AckW     = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT_CLKS);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CLKS - 1);
`ifdef SEQ_RETRY_EN
  localparam logic [1:0] MaxRetries = 2'd2;
`else
  localparam logic [1:0] MaxRetries = 2'd0;
`endif

  seq_state_t       state_q, state_d;
  err_code_t        code_q, code_d, fail_code;
  logic [15:0]      cmd_q, cmd_d, fifo_head;
  logic [7:0]       resp_q, resp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AckW-1:0]  acked_q, acked_d;
  logic [1:0]       retry_q, retry_d;
  logic             done_q, done_d, err_q, err_d;
  logic             pop, fail, timed_out;

  seq_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_cmd),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (empty)
  );

  assign busy = (state_q == StIssue) || (state_q == StWaitSent) ||
                (state_q == StWaitResp) || (state_q == StCheck);
  // >= so a counter that passed the limit while leaving WAIT_SENT still trips.
  assign timed_out = (cnt_q >= CntLimit);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    resp_d    = resp_q;
    cnt_d     = (cnt_q != CntMax) ? cnt_q + 1'b1 : cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
    acked_d   = acked_q;
    retry_d   = retry_q;
    pop       = 1'b0;
    fail      = 1'b0;
    fail_code = ErrNone;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ErrNone;
          acked_d = '0;
          retry_d = '0;
          if (empty) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StIssue;
            pop     = 1'b1;
          end
        end
      end
      StIssue: state_d = StWaitSent;
      StWaitSent: begin
        if (cmd_sent && resp_rdy) begin
          state_d = StCheck;
          resp_d  = resp;
        end else if (cmd_sent) begin
          state_d = StWaitResp;
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StWaitResp: begin
        if (resp_rdy) begin
          state_d = StCheck;
          resp_d  = resp;
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StCheck: begin
        if (resp_q == POS_ACK) begin
          acked_d = acked_q + 1'b1;
          retry_d = '0;
          if (empty) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StIssue;
            pop     = 1'b1;
          end
        end else begin
          fail      = 1'b1;
          fail_code = ErrNack;
        end
      end
      StDone, StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A retry reissues the held command word without popping.
    if (fail) begin
      if (retry_q != MaxRetries) begin
        retry_d = retry_q + 1'b1;
        state_d = StIssue;
      end else begin
        state_d = StErr;
        err_d   = 1'b1;
        code_d  = fail_code;
      end
    end

    if (abort && busy) begin
      state_d = StErr;
      err_d   = 1'b1;
      code_d  = ErrAbort;
      pop     = 1'b0;
    end

    if (pop) cmd_d = fifo_head;
    if (state_d == StIssue) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      acked_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      acked_q <= acked_d;
      retry_q <= retry_d;
    end
  end

  assign cmd      = cmd_q;
  assign send_cmd = (state_q == StIssue);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign n_acked  = acked_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed + randomized bench for tour_cmd_sequencer against a transaction-level queue model.
module tb_tour_cmd_sequencer;
  import tour_seq_pkg::CAL_GYRO;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 200;
  localparam logic [7:0]  ACK   = 8'hA5;
  localparam int MResp = 0, MSilent = 1, MAbort = 2, MReset = 3;
`ifdef SEQ_RETRY_EN
  localparam int MaxRetries = 2;
`else
  localparam int MaxRetries = 0;
`endif

  logic        clk, rst, wr_en, full, empty, start, abort, send_cmd, cmd_sent, resp_rdy;
  logic        busy, done, err;
  logic [15:0] wr_cmd, cmd;
  logic [7:0]  resp;
  logic [1:0]  err_code;
  logic [3:0]  n_acked;

  tour_cmd_sequencer #(
    .DEPTH        (DEPTH),
    .TIMEOUT_CLKS (TMO),
    .POS_ACK      (ACK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_cmd   (wr_cmd),
    .full     (full),
    .empty    (empty),
    .start    (start),
    .abort    (abort),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .n_acked  (n_acked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: queued commands plus expected run outcome.
  logic [15:0] mq[$];
  logic [15:0] cur_cmd;
  bit          run_over, next_new, exp_done, exp_err;
  int          exp_code, exp_acked, retries;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd"}, cmd, 0);
    check({tag, "_send"}, send_cmd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_acked"}, n_acked, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
  endtask

  task automatic push(input logic [15:0] c);
    wr_en  = 1'b1;
    wr_cmd = c;
    @(negedge clk);
    wr_en  = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(c);
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    exp_done  = 0;
    exp_err   = 0;
    exp_code  = 0;
    exp_acked = 0;
    retries   = 0;
    next_new  = 1;
    run_over  = (mq.size() == 0);
    if (run_over) exp_done = 1;
  endtask

  task automatic model_ack();
    exp_acked++;
    retries  = 0;
    next_new = 1;
    if (mq.size() == 0) begin
      run_over = 1;
      exp_done = 1;
    end
  endtask

  task automatic model_fail(input int code);
    if (retries < MaxRetries) begin
      retries++;
      next_new = 0;
    end else begin
      run_over = 1;
      exp_err  = 1;
      exp_code = code;
    end
  endtask

  // Acts as RemoteComm for one send_cmd; dly==0 returns resp with cmd_sent.
  task automatic serve(input int mode, input logic [7:0] rsp, input int dly,
                       input bit mid_push, input logic [15:0] mid_cmd);
    bit seen;
    int lat;
    seen = 0;
    for (int n = 0; n < TMO + 40; n++) begin
      if (send_cmd === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("send_seen", seen, 1);
    if (!seen) begin
      run_over = 1;
      return;
    end
    if (next_new) cur_cmd = mq.pop_front();
    check("cmd_word", cmd, cur_cmd);
    @(negedge clk);
    if (mode == MSilent) begin
      model_fail(2);
      if (run_over) begin
        lat = 1;
        while (err !== 1'b1 && lat < TMO + 10) begin
          @(negedge clk);
          lat++;
        end
        check("timeout_latency", lat, TMO);
      end
      return;
    end
    repeat ($urandom_range(3, 0)) @(negedge clk);
    if (mid_push) push(mid_cmd);
    cmd_sent = 1'b1;
    if (mode == MResp && dly == 0) begin
      resp_rdy = 1'b1;
      resp     = rsp;
    end
    @(negedge clk);
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    if (mode == MAbort) begin
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      run_over = 1;
      exp_err  = 1;
      exp_code = 3;
      return;
    end
    if (mode == MReset) begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset("midrun_rst");
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      run_over  = 1;
      exp_done  = 0;
      exp_err   = 0;
      exp_code  = 0;
      exp_acked = 0;
      return;
    end
    if (dly != 0) begin
      repeat (dly - 1) @(negedge clk);
      resp_rdy = 1'b1;
      resp     = rsp;
      @(negedge clk);
      resp_rdy = 1'b0;
    end
    if (rsp == ACK) model_ack();
    else model_fail(1);
  endtask

  task automatic finish_run(input string tag);
    int  n;
    bit  extra;
    n     = 0;
    extra = 0;
    while (busy === 1'b1 && n < 4 * TMO) begin
      if (send_cmd === 1'b1) extra = 1;
      @(negedge clk);
      n++;
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_extra_send"}, extra, 0);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_code"}, err_code, exp_code);
    check({tag, "_acked"}, n_acked, exp_acked);
    check({tag, "_empty"}, empty, mq.size() == 0);
    check({tag, "_full"}, full, mq.size() == DEPTH);
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_nack();
    logic [7:0] r;
    r = 8'($urandom_range(255, 0));
    if (r == ACK) r = 8'h00;
    return r;
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_cmd = '0; start = 1'b0; abort = 1'b0;
    cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two commands, both acked after 50 clocks.
    push(CAL_GYRO);
    push(16'h47F1);
    start_run();
    for (int k = 0; k < 20 && !run_over; k++) serve(MResp, ACK, 50, 0, '0);
    finish_run("two_acks");

    // Negative response.
    push(16'h47F1);
    start_run();
    for (int k = 0; k < 20 && !run_over; k++) serve(MResp, 8'h5A, 3, 0, '0);
    finish_run("nack");

    // Silent responder.
    push(16'($urandom));
    start_run();
    for (int k = 0; k < 20 && !run_over; k++) serve(MSilent, ACK, 0, 0, '0);
    finish_run("timeout");

    // Overfill: DEPTH+1 pushes, last one dropped.
    for (int i = 0; i < DEPTH; i++) push(16'($urandom));
    check("full_after_depth", full, 1);
    push(16'hDEAD);
    check("full_after_drop", full, 1);
    start_run();
    for (int k = 0; k < 40 && !run_over; k++)
      serve(MResp, ACK, $urandom_range(6, 0), 0, '0);
    finish_run("overfill");

    // Abort during second command, then resume.
    for (int i = 0; i < 3; i++) push(16'($urandom));
    start_run();
    serve(MResp, ACK, 4, 0, '0);
    serve(MAbort, ACK, 0, 0, '0);
    finish_run("abort");
    start_run();
    for (int k = 0; k < 20 && !run_over; k++) serve(MResp, ACK, 2, 0, '0);
    finish_run("resume");

    // Reset mid-run, then start on an empty queue.
    push(16'h1234);
    push(16'h5678);
    start_run();
    serve(MReset, ACK, 0, 0, '0);
    finish_run("after_rst");
    start_run();
    finish_run("empty_start");

    // Randomized runs: mixed acks/nacks, random latencies, occasional mid-run pushes.
    for (int r = 0; r < 8; r++) begin
      int n_push;
      n_push = $urandom_range(DEPTH - mq.size(), 0);
      for (int i = 0; i < n_push; i++) push(16'($urandom));
      start_run();
      for (int k = 0; k < 40 && !run_over; k++) begin
        logic [7:0] rsp;
        bit         mp;
        rsp = ($urandom_range(3, 0) != 0) ? ACK : rand_nack();
        mp  = (mq.size() < DEPTH) && ($urandom_range(3, 0) == 0);
        serve(MResp, rsp, $urandom_range(6, 0), mp, 16'($urandom));
      end
      finish_run("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
